// File: rtl/bus_master_if_pkg.sv
// ---------------------------------------------------------------------------
// bus_master_if_pkg
// Shared system-bus definitions: active-low enable levels, read/write
// encoding, bus widths, master-interface FSM state encodings and the default
// watchdog limit. Imported by every block that talks to the shared bus.
// No ports (package).
// ---------------------------------------------------------------------------
package bus_master_if_pkg;

    // Active-low control levels used by req_/grnt_/as_/ready_.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Bus read/write encoding.
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Bus geometry.
    localparam int ADDR_WIDTH = 30;
    localparam int DATA_WIDTH = 32;

    // Default watchdog limit in WAIT cycles; 0 disables the watchdog.
    localparam int BUS_IF_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        BUS_IF_IDLE   = 2'd0,
        BUS_IF_REQ    = 2'd1,
        BUS_IF_ACCESS = 2'd2,
        BUS_IF_WAIT   = 2'd3
    } bus_if_state_e;

    // Counter width able to hold 0..timeout; never narrower than one bit so a
    // disabled watchdog still elaborates to a legal vector.
    function automatic int wdog_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bus_master_if_if.sv
// ---------------------------------------------------------------------------
// bus_master_if_if
// One master port group of the shared system bus plus the muxed slave
// response it sees.
//   m_req_     master -> bus   bus request, active-low
//   m_grnt_    bus -> master   bus grant, active-low
//   m_as_      master -> bus   address strobe, active-low
//   m_rw       master -> bus   1=READ, 0=WRITE
//   m_addr     master -> bus   word address
//   m_wr_data  master -> bus   write data
//   s_ready_   bus -> master   muxed slave ready, active-low
//   s_rd_data  bus -> master   muxed slave read data
// Modports: master (the initiator adapter), slave (the bus / arbiter side).
// ---------------------------------------------------------------------------
interface bus_master_if_if
    import bus_master_if_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH
);
    logic              m_req_;
    logic              m_grnt_;
    logic              m_as_;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wr_data;
    logic              s_ready_;
    logic [DATA_W-1:0] s_rd_data;

    modport master (
        output m_req_, m_as_, m_rw, m_addr, m_wr_data,
        input  m_grnt_, s_ready_, s_rd_data
    );

    modport slave (
        input  m_req_, m_as_, m_rw, m_addr, m_wr_data,
        output m_grnt_, s_ready_, s_rd_data
    );
endinterface

// File: rtl/bus_master_if_watchdog.sv
// ---------------------------------------------------------------------------
// bus_watchdog
// Saturating cycle counter that flags a hung bus access. Counts cycles while
// enable is high; expired is high during the TIMEOUT-th counted cycle
// (count == TIMEOUT-1). TIMEOUT = 0 disables it (expired never rises).
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   clear    in   restart the count from zero at the next edge
//   enable   in   count this cycle
//   expired  out  limit reached in the current cycle
// ---------------------------------------------------------------------------
module bus_watchdog
    import bus_master_if_pkg::*;
#(
    parameter int TIMEOUT = BUS_IF_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = wdog_width(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    // Saturates at TIMEOUT so a long enable never wraps back into range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != CNT_W'(TIMEOUT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_master_if.sv
// ---------------------------------------------------------------------------
// bus_master_if
// Initiator-side adapter: turns a level core request into one complete bus
// transaction (req_/grnt_ arbitration, one-cycle as_ strobe, wait for
// ready_, release) with a watchdog that ends hung accesses with an error.
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   core_req      in   level request, held until core_ack
//   core_rw       in   1=READ, 0=WRITE
//   core_addr     in   word address
//   core_wr_data  in   write data
//   core_busy     out  high whenever the FSM is not IDLE
//   core_ack      out  one-cycle completion pulse
//   core_rd_data  out  read data, valid with core_ack, held until next ack
//   core_err      out  timeout flag, valid with core_ack, held until next ack
//   bus           master modport of the bus port group
// All outputs are registered except core_busy (decoded from state).
// ---------------------------------------------------------------------------
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int ADDR_W  = ADDR_WIDTH,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int TIMEOUT = BUS_IF_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic              core_busy,
    output logic              core_ack,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_err,
    bus_master_if_if.master   bus
);
    bus_if_state_e     r_state, w_next_state;

    logic              r_req_,   w_req_n;
    logic              r_as_,    w_as_n;
    logic              r_rw,     w_rw_n;
    logic [ADDR_W-1:0] r_addr,   w_addr_n;
    logic [DATA_W-1:0] r_wdata,  w_wdata_n;
    logic              r_ack,    w_ack_n;
    logic [DATA_W-1:0] r_rdata,  w_rdata_n;
    logic              r_err,    w_err_n;

    logic              w_wd_clear;
    logic              w_wd_enable;
    logic              w_wd_expired;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_wd_expired)
    );

    // NOTE: every variable gets its hold/default value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_req_n      = r_req_;
        w_as_n       = r_as_;
        w_rw_n       = r_rw;
        w_addr_n     = r_addr;
        w_wdata_n    = r_wdata;
        w_ack_n      = 1'b0;
        w_rdata_n    = r_rdata;
        w_err_n      = r_err;
        w_wd_clear   = 1'b0;
        w_wd_enable  = 1'b0;

        unique case (r_state)
            BUS_IF_IDLE: begin
                // r_ack high means core_req is still the finished
                // transaction's request; it must not start a second one.
                if (core_req && !r_ack) begin
                    w_rw_n       = core_rw;
                    w_addr_n     = core_addr;
                    w_wdata_n    = core_wr_data;
                    w_req_n      = ENABLE_;
                    w_next_state = BUS_IF_REQ;
                end
            end

            BUS_IF_REQ: begin
                if (bus.m_grnt_ == ENABLE_) begin
                    w_as_n       = ENABLE_;
                    w_next_state = BUS_IF_ACCESS;
                end
            end

            BUS_IF_ACCESS: begin
                // ready_ is deliberately not looked at until the strobe ends.
                w_as_n       = DISABLE_;
                w_wd_clear   = 1'b1;
                w_next_state = BUS_IF_WAIT;
            end

            BUS_IF_WAIT: begin
                // Ready is tested first so it wins over a same-cycle timeout.
                if (bus.s_ready_ == ENABLE_) begin
                    w_ack_n      = 1'b1;
                    w_err_n      = 1'b0;
                    w_rdata_n    = (r_rw == WRITE) ? '0 : bus.s_rd_data;
                    w_req_n      = DISABLE_;
                    w_next_state = BUS_IF_IDLE;
                end else if (w_wd_expired) begin
                    w_ack_n      = 1'b1;
                    w_err_n      = 1'b1;
                    w_rdata_n    = '0;
                    w_req_n      = DISABLE_;
                    w_next_state = BUS_IF_IDLE;
                end else begin
                    w_wd_enable  = 1'b1;
                end
            end

            default: begin
                w_next_state = BUS_IF_IDLE;
            end
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BUS_IF_IDLE;
            r_req_  <= DISABLE_;
            r_as_   <= DISABLE_;
            r_rw    <= READ;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_req_  <= w_req_n;
            r_as_   <= w_as_n;
            r_rw    <= w_rw_n;
            r_addr  <= w_addr_n;
            r_wdata <= w_wdata_n;
            r_ack   <= w_ack_n;
            r_rdata <= w_rdata_n;
            r_err   <= w_err_n;
        end
    end

    assign core_busy     = (r_state != BUS_IF_IDLE);
    assign core_ack      = r_ack;
    assign core_rd_data  = r_rdata;
    assign core_err      = r_err;

    assign bus.m_req_    = r_req_;
    assign bus.m_as_     = r_as_;
    assign bus.m_rw      = r_rw;
    assign bus.m_addr    = r_addr;
    assign bus.m_wr_data = r_wdata;

endmodule
